// File: rtl/time_align_pkg.sv
// ---------------------------------------------------------------------------
// time_align_pkg
//
// Shared definitions for the N-stage time aligner:
//   ta_state_e    - priming FSM states (fill the delay lines, then run)
//   data_w()      - width of the aligned output word
//   fill_w()      - width of the priming fill counter
//   TA_MAX_STAGES - largest supported slice count
// ---------------------------------------------------------------------------
package time_align_pkg;

    localparam int TA_MAX_STAGES = 16;

    typedef enum logic {
        TA_FILL = 1'b0,
        TA_RUN  = 1'b1
    } ta_state_e;

    function automatic int data_w(input int stages, input int slice_w);
        return stages * slice_w;
    endfunction

    // The fill counter must reach stages-1, which fits in $clog2(stages) bits.
    function automatic int fill_w(input int stages);
        return $clog2(stages);
    endfunction

endpackage

// File: rtl/time_align_nstage_delay.sv
// ---------------------------------------------------------------------------
// ta_delay_line
//
// Fixed-depth shift register used for one slice or for the valid bit.
// DEPTH=0 degenerates to a plain wire so the caller can feed the shared
// output register directly.
//
// Ports:
//   clk_i    clock, posedge
//   reset_i  synchronous active-low reset, clears every stage
//   ce_i     clock enable, low holds every stage
//   clr_i    synchronous clear, overrides ce_i
//   d_i      input word
//   q_o      word delayed by DEPTH enabled cycles
// ---------------------------------------------------------------------------
module ta_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ce_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;

        // Control inputs have no function for a zero-depth line.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, reset_i, ce_i, clr_i};
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [DEPTH];

        // NOTE: every stage is cleared on reset/flush, not just the last one;
        // stale data left in the middle of the chain would otherwise resurface
        // as a sample that was never sent after the clear.
        always_ff @(posedge clk_i) begin
            if (!reset_i || clr_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else if (ce_i) begin
                // NOTE: non-blocking assignments let every stage read the old
                // value of its neighbour, so the chain shifts by exactly one.
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/time_align_nstage.sv
// ---------------------------------------------------------------------------
// time_align_nstage
//
// Realigns a sample delivered as NUM_STAGES staggered slices (slice 0 first,
// slice k k cycles later) into one output word. Slice k is delayed by
// NUM_STAGES-1-k registers and then captured, together with all other
// slices, into the shared output register. A valid bit rides alongside
// slice 0. A priming FSM reports when the delay lines have been filled, and
// a saturating counter tallies the aligned words.
//
// Ports:
//   clk_i       clock, posedge
//   reset_i     synchronous active-low reset (highest priority)
//   ce_i        clock enable, low holds every register
//   flush_i     synchronous clear of in-flight data, valids, FSM and counter
//   valid_i     slice 0 of a real sample is on slice_i this cycle
//   slice_i     staggered slices, slice 0 in the MSBs
//   dout_o      aligned word {slice0, ..., sliceN-1}
//   valid_o     dout_o holds a complete sample
//   primed_o    delay lines filled since the last reset or flush
//   word_cnt_o  saturating count of valid_o words
// ---------------------------------------------------------------------------
module time_align_nstage
    import time_align_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int SLICE_W    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          ce_i,
    input  logic                          flush_i,
    input  logic                          valid_i,
    input  logic [NUM_STAGES*SLICE_W-1:0] slice_i,
    output logic [NUM_STAGES*SLICE_W-1:0] dout_o,
    output logic                          valid_o,
    output logic                          primed_o,
    output logic [CNT_W-1:0]              word_cnt_o
);

    localparam int DATA_W = data_w(NUM_STAGES, SLICE_W);
    localparam int FILL_W = fill_w(NUM_STAGES);

    logic [SLICE_W-1:0] aligned [NUM_STAGES];
    logic [DATA_W-1:0]  aligned_word;
    logic               vld_aligned;

    // Triangular delay structure: early slices wait longer.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
        ta_delay_line #(
            .DEPTH(NUM_STAGES - 1 - k),
            .WIDTH(SLICE_W)
        ) u_dl (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .ce_i   (ce_i),
            .clr_i  (flush_i),
            .d_i    (slice_i[(NUM_STAGES-k)*SLICE_W-1 -: SLICE_W]),
            .q_o    (aligned[k])
        );
    end

    // The valid bit matches slice 0's delay so it lands with the full word.
    ta_delay_line #(
        .DEPTH(NUM_STAGES - 1),
        .WIDTH(1)
    ) u_vld (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .ce_i   (ce_i),
        .clr_i  (flush_i),
        .d_i    (valid_i),
        .q_o    (vld_aligned)
    );

    // NOTE: the default assignment before the loop keeps this purely
    // combinational; without it a tool may infer a latch on any bit the
    // loop does not reach.
    always_comb begin
        aligned_word = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            aligned_word[(NUM_STAGES-k)*SLICE_W-1 -: SLICE_W] = aligned[k];
        end
    end

    // Shared output register and aligned-word counter. dout_o follows the
    // chains every enabled cycle; consumers qualify it with valid_o.
    always_ff @(posedge clk_i) begin
        if (!reset_i || flush_i) begin
            dout_o     <= '0;
            valid_o    <= 1'b0;
            word_cnt_o <= '0;
        end else if (ce_i) begin
            dout_o  <= aligned_word;
            valid_o <= vld_aligned;
            if (vld_aligned && (word_cnt_o != '1)) begin
                word_cnt_o <= word_cnt_o + 1'b1;
            end
        end
    end

    // Priming FSM: count enabled edges until every chain has been refilled.
    ta_state_e         state_q;
    logic [FILL_W-1:0] fill_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i || flush_i) begin
            state_q    <= TA_FILL;
            fill_cnt_q <= '0;
            primed_o   <= 1'b0;
        end else if (ce_i) begin
            case (state_q)
                TA_FILL: begin
                    // Current count is one short of NUM_STAGES-1: this edge fills.
                    if (fill_cnt_q == FILL_W'(NUM_STAGES - 2)) begin
                        state_q    <= TA_RUN;
                        fill_cnt_q <= FILL_W'(NUM_STAGES - 1);
                        primed_o   <= 1'b1;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                    end
                end
                TA_RUN: begin
                    state_q <= TA_RUN;
                end
                default: begin
                    state_q    <= TA_FILL;
                    fill_cnt_q <= '0;
                    primed_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
